// File: rtl/mult_error_accum_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_error_accum_if
// Description : Sample-pair stream carrying (exact, approx) products into the
//               error accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_error_accum_if #(
    parameter int W = 16
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] exact;
    logic [W-1:0] approx;

    modport master (
        output in_valid,
        output exact,
        output approx,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  exact,
        input  approx,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/mult_error_accum.sv
`default_nettype none
// ============================================================================
// Module      : mult_error_accum
// Description : Accumulates error statistics (error count, sum / max of error
//               distance) of an approximate multiplier over a window of
//               2**SAMPLES_LOG2 product pairs. The signed bias sum is built
//               only when ERR_SIGNED_SUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_error_accum #(
    parameter int W            = 16,
    parameter int SAMPLES_LOG2 = 8,
    parameter int ACC_W        = W + SAMPLES_LOG2
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    i_start,
    mult_error_accum_if.slave            s_in,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [SAMPLES_LOG2:0]        o_err_count,
    output logic [ACC_W-1:0]             o_sum_ed,
    output logic [W-1:0]                 o_max_ed,
    output logic [ACC_W:0]               o_sum_bias
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [SAMPLES_LOG2-1:0] c_CNT_LAST = '1;

    logic [1:0]              r_state;
    logic [SAMPLES_LOG2-1:0] r_cnt;

    logic                    r_s1_vld;
    logic [W-1:0]            r_s1_ed;
    logic                    r_s1_neq;

    logic [SAMPLES_LOG2:0]   r_err_count;
    logic [ACC_W-1:0]        r_sum_ed;
    logic [W-1:0]            r_max_ed;

    logic                    w_accept;
    logic                    w_clear;
    logic [W-1:0]            w_ed;
    logic                    w_neq;

    assign s_in.in_ready = (r_state == c_RUN);
    assign w_accept      = s_in.in_valid && (r_state == c_RUN);
    assign w_clear       = i_start && ((r_state == c_IDLE) || (r_state == c_DONE));

    assign w_ed  = (s_in.exact >= s_in.approx) ? (s_in.exact - s_in.approx)
                                               : (s_in.approx - s_in.exact);
    assign w_neq = (s_in.exact != s_in.approx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (w_clear) begin
                        r_state <= c_RUN;
                        r_cnt   <= '0;
                    end
                end
                c_RUN: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_CNT_LAST) begin
                            r_state <= c_DRAIN;
                        end
                    end
                end
                c_DRAIN: r_state <= c_DONE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Stage 1: distance and inequality of the accepted pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_ed  <= '0;
            r_s1_neq <= 1'b0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_ed  <= w_ed;
                r_s1_neq <= w_neq;
            end
        end
    end

    // Stage 2: fold into the window statistics. The last sample lands during DRAIN,
    // so a clear (only possible in IDLE/DONE) never collides with a commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
            r_sum_ed    <= '0;
            r_max_ed    <= '0;
        end else if (w_clear) begin
            r_err_count <= '0;
            r_sum_ed    <= '0;
            r_max_ed    <= '0;
        end else if (r_s1_vld) begin
            r_err_count <= r_err_count + {{SAMPLES_LOG2{1'b0}}, r_s1_neq};
            r_sum_ed    <= r_sum_ed + {{(ACC_W-W){1'b0}}, r_s1_ed};
            if (r_s1_ed > r_max_ed) begin
                r_max_ed <= r_s1_ed;
            end
        end
    end

`ifdef ERR_SIGNED_SUM_EN
    logic [ACC_W:0] r_s1_bias;
    logic [ACC_W:0] r_sum_bias;
    logic [ACC_W:0] w_bias;

    // Zero-extending both operands past W+1 bits makes the difference a correct
    // two's-complement value of (approx - exact).
    assign w_bias = {{(ACC_W+1-W){1'b0}}, s_in.approx} - {{(ACC_W+1-W){1'b0}}, s_in.exact};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_bias <= '0;
        end else if (w_accept) begin
            r_s1_bias <= w_bias;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_bias <= '0;
        end else if (w_clear) begin
            r_sum_bias <= '0;
        end else if (r_s1_vld) begin
            r_sum_bias <= r_sum_bias + r_s1_bias;
        end
    end

    assign o_sum_bias = r_sum_bias;
`else
    assign o_sum_bias = '0;
`endif

    assign o_busy      = (r_state == c_RUN) || (r_state == c_DRAIN);
    assign o_done      = (r_state == c_DONE);
    assign o_err_count = r_err_count;
    assign o_sum_ed    = r_sum_ed;
    assign o_max_ed    = r_max_ed;

endmodule
`default_nettype wire
